issue_queue: RTL

- Out-of-order issue queue that sits directly downstream of rename.
- Buffers renamed instructions (rinstr_t) and tracks source-operand readiness through physical-register wakeup broadcasts.
- Issues the oldest fully-ready entry to the execute stage under a valid/ready handshake.
- Squashes speculative entries when a single outstanding branch is mispredicted.

---
 rtl/core_pkg.sv | 39 +++
 rtl/iq_select.sv | 23 ++
 rtl/issue_queue.sv | 133 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: physical-register tags, renamed instructions, branch results,
// and the issue-queue entry layout.
package core_pkg;

  localparam int PREG_W   = 6;
  localparam int OP_W     = 8;
  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [PREG_W-1:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
    p_reg_t          rd;
    p_reg_t          rs1;
    p_reg_t          rs2;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  typedef struct packed {
    logic    valid;
    logic    spec;
    rinstr_t rinstr;
  } iq_entry_t;

  // An unused source slot never blocks issue.
  function automatic logic src_ready(input p_reg_t src);
    return src.ready || !src.valid;
  endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index priority encoder: grants the oldest requesting entry.
module iq_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    // Walk downward so the lowest requesting index is the last write.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_idx_o = IDX_W'(i);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue: wakeup on writeback, oldest-ready select,
// single-branch speculation with squash-and-compact on mispredict.
module issue_queue
  import core_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  rinstr_t    rinstr_i,
  input  logic       is_branch_i,
  output logic       iq_full_o,
  input  p_reg_t     wb_i,
  input  br_result_t br_result_i,
  output rinstr_t    iinstr_o,
  input  logic       ex_ready_i
);

  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t        entries_q [DEPTH];
  iq_entry_t        entries_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             br_pending_q, br_pending_d;

  iq_entry_t        woke [DEPTH];
  iq_entry_t        new_entry;
  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] keep;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             iss, enq, br_resolve, mispredict;
  logic             unused_wb_ready;

  assign unused_wb_ready = wb_i.ready;

  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = entries_q[i].valid
                && src_ready(entries_q[i].rinstr.rs1)
                && src_ready(entries_q[i].rinstr.rs2);
    end
  end

  iq_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .req_i     (rdy_vec),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    iinstr_o = '0;
    if (gnt_vld) begin
      iinstr_o       = entries_q[gnt_idx].rinstr;
      iinstr_o.valid = 1'b1;
    end
  end

  assign iss        = gnt_vld && ex_ready_i;
  assign br_resolve = br_result_i.valid && br_pending_q;
  assign mispredict = br_resolve && !br_result_i.hit;
  assign iq_full_o  = (count_q == CNT_W'(DEPTH))
                   || (rinstr_i.valid && is_branch_i && br_pending_q);
  // Anything arriving alongside a mispredict is younger than the branch.
  assign enq        = rinstr_i.valid && !iq_full_o && !mispredict;

  always_comb begin
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.spec   = br_pending_q && !br_resolve && !is_branch_i;
    new_entry.rinstr = rinstr_i;
    if (wb_i.valid && rinstr_i.rs1.idx == wb_i.idx) new_entry.rinstr.rs1.ready = 1'b1;
    if (wb_i.valid && rinstr_i.rs2.idx == wb_i.idx) new_entry.rinstr.rs2.ready = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = entries_q[i];
      if (wb_i.valid && woke[i].valid) begin
        if (woke[i].rinstr.rs1.idx == wb_i.idx) woke[i].rinstr.rs1.ready = 1'b1;
        if (woke[i].rinstr.rs2.idx == wb_i.idx) woke[i].rinstr.rs2.ready = 1'b1;
      end
      if (br_resolve && br_result_i.hit) woke[i].spec = 1'b0;
      keep[i] = woke[i].valid
             && !(iss && gnt_idx == IDX_W'(i))
             && !(mispredict && woke[i].spec);
    end
  end

  always_comb begin
    logic [CNT_W-1:0] pos;
    pos = '0;
    for (int j = 0; j < DEPTH; j++) entries_d[j] = '0;

    // Survivors pack downward in age order; pos ends as the survivor count.
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (pos == CNT_W'(j)) entries_d[j] = woke[i];
        end
        pos = pos + CNT_W'(1);
      end
    end

    if (enq) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (pos == CNT_W'(j)) entries_d[j] = new_entry;
      end
    end

    count_d = pos + CNT_W'(enq);

    br_pending_d = br_pending_q;
    if (br_resolve)          br_pending_d = 1'b0;
    if (enq && is_branch_i)  br_pending_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q      <= '0;
      br_pending_q <= 1'b0;
    end else begin
      entries_q    <= entries_d;
      count_q      <= count_d;
      br_pending_q <= br_pending_d;
    end
  end

endmodule
